// File: rtl/rr_stream_mux.sv
// M-to-1 valid/ready stream mux with round-robin or fixed-select arbitration.
// Optional packet locking on A_last is enabled by defining RRMUX_LAST_LOCK_EN.
module rr_stream_mux #(
    parameter int N = 3,
    parameter int M = 8,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [M*W-1:0] A,
    input  logic [M-1:0]   A_valid,
    output logic [M-1:0]   A_ready,
    input  logic           MODE,
    input  logic [N-1:0]   S,
`ifdef RRMUX_LAST_LOCK_EN
    input  logic [M-1:0]   A_last,
    output logic           Y_last,
`endif
    output logic [W-1:0]   Y,
    output logic           Y_valid,
    input  logic           Y_ready,
    output logic [N-1:0]   Y_sel
);

    logic [N-1:0] ptr;
    logic [N-1:0] g;
    logic [N-1:0] idx;
    logic         found;
    logic         load_en;
    logic         xfer;
    logic [M-1:0] elig;
    logic [W-1:0] chan [M];

`ifdef RRMUX_LAST_LOCK_EN
    logic         lock;
    logic [N-1:0] lock_ch;
`endif

    always_comb begin
        for (int i = 0; i < M; i++) begin
            chan[i] = A[i*W +: W];
        end
    end

    assign load_en = !Y_valid || Y_ready;

    always_comb begin
        elig = '0;
        if (MODE) begin
            if (32'(S) < M) elig[S] = A_valid[S];
        end
`ifdef RRMUX_LAST_LOCK_EN
        else if (lock) begin
            elig[lock_ch] = A_valid[lock_ch];
        end
`endif
        else begin
            elig = A_valid;
        end
    end

    // Search starts just after the last grant, so the last winner goes last.
    always_comb begin
        found = 1'b0;
        g     = ptr;
        idx   = '0;
        for (int k = 1; k <= M; k++) begin
            idx = N'((int'(ptr) + k) % M);
            if (!found && elig[idx]) begin
                found = 1'b1;
                g     = idx;
            end
        end
    end

    always_comb begin
        A_ready = '0;
        if (found) A_ready[g] = load_en;
    end

    assign xfer = found && load_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Y       <= '0;
            Y_valid <= 1'b0;
            Y_sel   <= '0;
            ptr     <= N'(M - 1);
`ifdef RRMUX_LAST_LOCK_EN
            Y_last  <= 1'b0;
            lock    <= 1'b0;
            lock_ch <= '0;
`endif
        end else begin
            if (load_en) Y_valid <= found;
            if (xfer) begin
                Y     <= chan[g];
                Y_sel <= g;
                if (!MODE) ptr <= g;
`ifdef RRMUX_LAST_LOCK_EN
                Y_last <= A_last[g];
`endif
            end
`ifdef RRMUX_LAST_LOCK_EN
            if (MODE) begin
                lock <= 1'b0;
            end else if (xfer) begin
                lock    <= !A_last[g];
                lock_ch <= g;
            end
`endif
        end
    end

endmodule
